mem_initializer: RTL
====================

# mem_initializer

Parametrised memory fill engine. Writes a selectable pattern into every word of a single-port RAM, one word per clock. Successor to the fixed 8-bit identity initializer. Sits between the top-level control FSM and the S-array RAM of the RC4 datapath, and is reusable for any scratch RAM in the design.

## Interface

**Parameters**
- ADDR_WIDTH, default 8: RAM address width.
- DATA_WIDTH, default 8: RAM word width.
- DEPTH, default 256: number of words written. Legal range 2 .. 2^ADDR_WIDTH; violations are an elaboration error.

**Ports**
- clk, input, 1: single clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: synchronous request; rising edge detected internally.
- abort, input, 1: synchronous cancel of a fill in progress.
- mode, input, 2: pattern select; latched on accept.
- fill_value, input, DATA_WIDTH: constant / ramp base; latched on accept.
- step, input, DATA_WIDTH: ramp increment; latched on accept.
- write_enable, output, 1: RAM write strobe.
- address, output, ADDR_WIDTH: RAM address.
- ram_in, output, DATA_WIDTH: RAM write data.
- busy, output, 1: high while in WRITE.
- finished, output, 1: one-cycle pulse on completion.
- aborted, output, 1: one-cycle pulse on cancel.

## Operation

- **Modes** (k = word index 0..DEPTH-1; all arithmetic mod 2^DATA_WIDTH):
  - IDENTITY: data = k, zero-extended or truncated to DATA_WIDTH.
  - FILL: data = fill_value.
  - RAMP: data = fill_value + k·step. Computed by accumulation, not multiply.
  - DESCEND: data = DEPTH-1-k, truncated.
- **FSM states:** IDLE, WRITE, DONE.
- **IDLE**
  - A start rising edge moves to WRITE and latches mode, fill_value and step.
  - abort is ignored.
- **WRITE**
  - write_enable=1, address=k, ram_in=pattern(k); k increments each cycle.
  - At k=DEPTH-1, move to DONE.
  - The address counter never exceeds DEPTH-1. No overflow when DEPTH=2^ADDR_WIDTH.
- **DONE**
  - finished=1 for exactly one cycle, then IDLE.
- **abort in WRITE**
  - The word presented in that cycle is still written.
  - Next state is IDLE; aborted pulses one cycle; finished does not pulse.
  - Precedence: abort wins over the terminal-count transition in the same cycle.
- **start edge outside IDLE** (WRITE or DONE): dropped, not queued.
  - Holding start high never retriggers; a new low-to-high edge is required.
- **Outputs outside WRITE:** write_enable=0, address=0, ram_in=0.
- **Changes to mode/fill_value/step during WRITE:** no effect.

## Timing

- **Reset values** (asynchronous, while reset_n=0): state IDLE; all outputs 0; counter, accumulator and edge-detect register 0.
- **Reset mid-fill:** abandons immediately; no finished or aborted pulse.
- **Start latency:** start sampled 0 at edge N-1 and 1 at edge N → first write (address 0) in the cycle after edge N.
- **Write window:** exactly DEPTH consecutive write_enable cycles; no gaps.
- **Completion:** finished is high in the cycle after the last write, so start edge to finished = DEPTH+1 cycles.
- **Restart:** earliest accepted next start is a rising edge sampled in the cycle after finished.
- **Registered outputs:** write_enable, address and ram_in are registered, with no combinational path from inputs.
- **Combinational outputs:** busy and finished are decoded from state only.

## Structure

- **Package mem_init_pkg** holds:
  - mode_t enum: IDENTITY=0, FILL=1, RAMP=2, DESCEND=3.
  - state_t enum: IDLE, WRITE, DONE.
- **Sub-module rise_detect:** one register, out = in & ~in_q, async active-low reset. It replaces the previous trap-edge pair for start.
- **Datapath:** address counter plus data accumulator (RAMP/IDENTITY/DESCEND share one adder with a mode-selected increment: +step, +1, -1).

## Test plan

- **IDENTITY, defaults:** start pulse → 256 writes, address 0..255 with ram_in equal to address; finished at cycle 257; write_enable=0 afterwards.
- **RAMP, DATA_WIDTH=8, DEPTH=16:** fill_value=0xF0, step=0x11 → ram_in sequence F0,01,12,…; wraps mod 256; exactly 16 writes.
- **FILL, ADDR_WIDTH=4, DEPTH=10:** fill_value=0xA5 → addresses 0..9 all 0xA5; the counter never reaches 10.
- **abort in the same cycle as address 5 (DEPTH=256):** address 5 is written, aborted pulses, finished never asserts. abort asserted at address DEPTH-1 → aborted, not finished.
- **start held high for 600 cycles:** exactly one fill, one finished. A second start edge during WRITE is ignored (count still 256).
- **reset_n low mid-fill at address 100:** outputs 0 immediately. After release a new start yields a full fill beginning at address 0.

Source files
------------

// File: rtl/mem_init_pkg.sv
// Shared types for the memory fill engine: pattern selector and control FSM states.
package mem_init_pkg;

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        FILL     = 2'd1,
        RAMP     = 2'd2,
        DESCEND  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_initializer_rise_detect.sv
// Single-register rising-edge detector; the output pulses for one cycle per low-to-high input transition.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic out_o
);

    logic in_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_i;
        end
    end

    assign out_o = in_i & ~in_q;

endmodule

// File: rtl/mem_initializer.sv
// Memory fill engine: writes one pattern word per clock into addresses 0..DEPTH-1 of a single-port RAM.
module mem_initializer
    import mem_init_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic [DATA_WIDTH-1:0] step,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic                  busy,
    output logic                  finished,
    output logic                  aborted
);

    if (DEPTH < 2 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("mem_initializer: DEPTH must lie in 2 .. 2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] DESC_FIRST = DATA_WIDTH'(DEPTH - 1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]   acc_q;
    logic [DATA_WIDTH-1:0]   inc_q;
    logic                    we_q;
    logic                    aborted_q;
    logic                    start_rise;
    logic [DATA_WIDTH-1:0]   first_d;
    logic [DATA_WIDTH-1:0]   inc_d;

    rise_detect u_start_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (start),
        .out_o   (start_rise)
    );

    // Only the first word and the per-word increment depend on the mode; the
    // accumulator then needs a single adder for every pattern (FILL adds zero).
    always_comb begin
        first_d = '0;
        inc_d   = '0;
        case (mode_t'(mode))
            IDENTITY: begin first_d = '0;         inc_d = DATA_WIDTH'(1); end
            FILL:     begin first_d = fill_value; inc_d = '0;             end
            RAMP:     begin first_d = fill_value; inc_d = step;           end
            DESCEND:  begin first_d = DESC_FIRST; inc_d = '1;             end
            default:  begin first_d = '0;         inc_d = '0;             end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            inc_q     <= '0;
            we_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_q <= WRITE;
                        cnt_q   <= '0;
                        acc_q   <= first_d;
                        inc_q   <= inc_d;
                        we_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    // abort takes precedence over the terminal count
                    if (abort) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        we_q      <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (cnt_q == LAST_ADDR) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_WIDTH'(1);
                        acc_q <= acc_q + inc_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign write_enable = we_q;
    assign address      = cnt_q;
    assign ram_in       = acc_q;
    assign aborted      = aborted_q;
    assign busy         = (state_q == WRITE);
    assign finished     = (state_q == DONE);

endmodule
